// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: shift op encodings, sequencer state
// encoding and default datapath sizes.
package cpu_pkg;

   localparam int unsigned SEQ_WIDTH   = 16;
   localparam int unsigned SEQ_SHAMT_W = 4;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between issue, the shift sequencer and writeback.
//   request : in_valid/in_ready, in_data, in_amount, in_op, in_carry, flush
//   response: out_valid/out_ready, out_data, out_carry, out_zero, out_neg
// master = requester/consumer side, slave = sequencer side.
interface shift_sequencer_if #(
   parameter int unsigned WIDTH = cpu_pkg::SEQ_WIDTH
);
   import cpu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] in_amount;
   shift_op_t        in_op;
   logic             in_carry;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;
   logic             out_neg;

   modport master (
      output in_valid, in_data, in_amount, in_op, in_carry, flush, out_ready,
      input  in_ready, out_valid, out_data, out_carry, out_zero, out_neg
   );

   modport slave (
      input  in_valid, in_data, in_amount, in_op, in_carry, flush, out_ready,
      output in_ready, out_valid, out_data, out_carry, out_zero, out_neg
   );

endinterface

// File: rtl/shift_sequencer_shifter.sv
// Single-pass combinational barrel shifter (LSL/LSR/ASR/ROR).
//   i_data   : operand
//   i_shamt  : shift amount, 0..WIDTH-1
//   i_op     : shift operation
//   o_data_c : shifted result (combinational)
module shift_sequencer_shifter
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH   = SEQ_WIDTH,
   parameter int unsigned SHAMT_W = SEQ_SHAMT_W
) (
   input  logic [WIDTH-1:0]   i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
   input  shift_op_t          i_op,
   output logic [WIDTH-1:0]   o_data_c
);

   logic [2*WIDTH-1:0] w_rot;

   // Rotate by shifting a doubled copy right and keeping the low half.
   always_comb begin
      w_rot    = {i_data, i_data} >> i_shamt;
      o_data_c = i_data;
      case (i_op)
         SH_LSL:  o_data_c = i_data << i_shamt;
         SH_LSR:  o_data_c = i_data >> i_shamt;
         SH_ASR:  o_data_c = $unsigned($signed(i_data) >>> i_shamt);
         SH_ROR:  o_data_c = w_rot[WIDTH-1:0];
         default: o_data_c = i_data;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass shift sequencer: clamps/wraps a full-width shift amount and
// drives the narrow shifter one pass per cycle, returning a registered
// result with carry/zero/negative flags over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response interface (slave side)
module shift_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH   = SEQ_WIDTH,
   parameter int unsigned SHAMT_W = SEQ_SHAMT_W
) (
   input logic               clk,
   input logic               rst_n,
   shift_sequencer_if.slave  bus
);

   localparam int unsigned      REM_W    = SHAMT_W + 1;
   localparam logic [REM_W-1:0] MAX_PASS = REM_W'(WIDTH - 1);
   localparam logic [REM_W-1:0] FULL     = REM_W'(WIDTH);

   seq_state_t         r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_data;
   logic [REM_W-1:0]   r_rem;
   shift_op_t          r_op;
   logic               r_sat;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic               r_out_carry;
   logic               r_out_zero;
   logic               r_out_neg;

   logic               w_accept;
   logic               w_load_out;
   logic [WIDTH-1:0]   w_out_data;
   logic               w_out_carry;
   logic               w_amt_zero;
   logic               w_sat;
   logic [REM_W-1:0]   w_eff;
   logic [SHAMT_W-1:0] w_s;
   logic [SHAMT_W-1:0] w_idx_l;
   logic [SHAMT_W-1:0] w_idx_r;
   logic [REM_W-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   w_shift;
   logic [WIDTH-1:0]   w_fin_data;
   logic               w_fin_carry;

   shift_sequencer_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
      .i_data   (r_data),
      .i_shamt  (w_s),
      .i_op     (r_op),
      .o_data_c (w_shift)
   );

   // Effective amount: clamp to WIDTH for linear shifts, wrap for rotate.
   always_comb begin
      w_amt_zero = (bus.in_amount == '0);
      w_sat      = (bus.in_op != SH_ROR) && (bus.in_amount > WIDTH'(WIDTH));
      if (bus.in_op == SH_ROR)
         w_eff = {1'b0, bus.in_amount[SHAMT_W-1:0]};
      else if (bus.in_amount >= WIDTH'(WIDTH))
         w_eff = FULL;
      else
         w_eff = {1'b0, bus.in_amount[SHAMT_W-1:0]};
   end

   // Pass size, remaining count and final-pass result/carry.
   always_comb begin
      w_s         = (r_rem > MAX_PASS) ? SHAMT_W'(MAX_PASS) : r_rem[SHAMT_W-1:0];
      w_rem_nxt   = r_rem - {1'b0, w_s};
      w_idx_l     = ~w_s + SHAMT_W'(1);
      w_idx_r     = w_s - SHAMT_W'(1);
      w_fin_data  = w_shift;
      w_fin_carry = 1'b0;
      case (r_op)
         SH_LSL:  w_fin_carry = r_data[w_idx_l];
         SH_LSR,
         SH_ASR:  w_fin_carry = r_data[w_idx_r];
         SH_ROR:  w_fin_carry = w_shift[WIDTH-1];
         default: w_fin_carry = 1'b0;
      endcase
      // Over-range linear shifts saturate; ASR fills with the sign.
      if (r_sat) begin
         if (r_op == SH_ASR) begin
            w_fin_data  = {WIDTH{r_data[WIDTH-1]}};
            w_fin_carry = r_data[WIDTH-1];
         end else begin
            w_fin_data  = '0;
            w_fin_carry = 1'b0;
         end
      end
   end

   // Next-state and output-load decode; flush overrides accept and handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_load_out  = 1'b0;
      w_out_data  = w_fin_data;
      w_out_carry = w_fin_carry;
      case (r_state)
         ST_IDLE: begin
            if (!bus.flush && bus.in_valid && r_in_ready) begin
               w_accept = 1'b1;
               if (w_eff == '0) begin
                  w_state_nxt = ST_DONE;
                  w_load_out  = 1'b1;
                  w_out_data  = bus.in_data;
                  // Only ROR by a nonzero multiple of WIDTH lands here with amount != 0.
                  w_out_carry = w_amt_zero ? bus.in_carry : bus.in_data[WIDTH-1];
               end else begin
                  w_state_nxt = ST_PASS;
               end
            end
         end
         ST_PASS: begin
            if (bus.flush) begin
               w_state_nxt = ST_IDLE;
            end else if (w_rem_nxt == '0) begin
               w_state_nxt = ST_DONE;
               w_load_out  = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.flush || bus.out_ready)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data      <= '0;
         r_rem       <= '0;
         r_op        <= SH_LSL;
         r_sat       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_carry <= 1'b0;
         r_out_zero  <= 1'b0;
         r_out_neg   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_data <= bus.in_data;
            r_op   <= bus.in_op;
            r_sat  <= w_sat;
            r_rem  <= w_eff;
         end else if (r_state == ST_PASS && !bus.flush) begin
            r_data <= w_shift;
            r_rem  <= w_rem_nxt;
         end
         if (w_load_out) begin
            r_out_data  <= w_out_data;
            r_out_carry <= w_out_carry;
            r_out_zero  <= ~|w_out_data;
            r_out_neg   <= w_out_data[WIDTH-1];
         end
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_DONE);
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_carry = r_out_carry;
   assign bus.out_zero  = r_out_zero;
   assign bus.out_neg   = r_out_neg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a bit-serial reference model pushes
// expected results when a request is accepted; they are popped and compared
// when the sequencer presents out_valid.
`timescale 1ns/1ps
module tb_shift_sequencer;
   import cpu_pkg::*;

   localparam int unsigned W = 16;

   typedef struct {
      logic [W-1:0] data;
      logic         carry;
      logic         zero;
      logic         neg;
      int           lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   shift_sequencer_if #(.WIDTH(W)) bus ();

   shift_sequencer #(.WIDTH(W), .SHAMT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bit-at-a-time reference shift.
   function automatic exp_t model(input shift_op_t op, input logic [W-1:0] d,
                                  input logic [W-1:0] amt, input logic cin);
      exp_t         e;
      int           n;
      int           eff;
      logic         c;
      logic [W-1:0] x;
      c = cin;
      x = d;
      if (op == SH_ROR) begin
         eff = int'(amt) % W;
         n   = (amt != 0 && eff == 0) ? W : eff;
      end else begin
         eff = (amt > W) ? W : int'(amt);
         n   = (amt > 40) ? 40 : int'(amt);
      end
      for (int i = 0; i < n; i++) begin
         case (op)
            SH_LSL:  begin c = x[W-1]; x = {x[W-2:0], 1'b0}; end
            SH_LSR:  begin c = x[0];   x = {1'b0, x[W-1:1]}; end
            SH_ASR:  begin c = x[0];   x = {x[W-1], x[W-1:1]}; end
            default: begin x = {x[0], x[W-1:1]}; c = x[W-1]; end
         endcase
      end
      e.data  = x;
      e.carry = c;
      e.zero  = (x == '0);
      e.neg   = x[W-1];
      e.lat   = (eff == 0) ? 1 : (eff < W) ? 2 : 3;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input shift_op_t op, input logic [W-1:0] d,
                       input logic [W-1:0] amt, input logic cin, input bit track);
      int guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_op     = op;
      bus.in_data   = d;
      bus.in_amount = amt;
      bus.in_carry  = cin;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      if (track) sb.push_back(model(op, d, amt, cin));
   endtask

   // Wait for a result, compare it, optionally hold under backpressure, then retire.
   task automatic receive(input int hold);
      exp_t e;
      int   lat = 1;
      while (!bus.out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("latency",   32'(lat),           32'(e.lat));
      check("out_data",  32'(bus.out_data),  32'(e.data));
      check("out_carry", 32'(bus.out_carry), 32'(e.carry));
      check("out_zero",  32'(bus.out_zero),  32'(e.zero));
      check("out_neg",   32'(bus.out_neg),   32'(e.neg));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid",    32'(bus.out_valid), 32'd1);
         check("hold_data",     32'(bus.out_data),  32'(e.data));
         check("hold_carry",    32'(bus.out_carry), 32'(e.carry));
         check("hold_in_ready", 32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("valid_drop",    32'(bus.out_valid), 32'd0);
      check("in_ready_rise", 32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int guard;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amount = '0;
      bus.in_op     = SH_LSL;
      bus.in_carry  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_flags",     32'({bus.out_carry, bus.out_zero, bus.out_neg}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send(SH_LSL, 16'h0001, 16'd4,     1'b0, 1'b1); receive(0);
      send(SH_ASR, 16'h8000, 16'd16,    1'b0, 1'b1); receive(0);
      send(SH_LSR, 16'hFFFF, 16'h0100,  1'b0, 1'b1); receive(0);
      send(SH_LSR, 16'hA5C3, 16'd0,     1'b1, 1'b1); receive(0);
      send(SH_ROR, 16'h1234, 16'd20,    1'b0, 1'b1); receive(0);
      send(SH_ROR, 16'h1234, 16'd16,    1'b1, 1'b1); receive(0);
      send(SH_LSL, 16'h8001, 16'd15,    1'b0, 1'b1); receive(0);
      send(SH_ASR, 16'h4000, 16'hFFFF,  1'b1, 1'b1); receive(0);
      send(SH_ASR, 16'hC000, 16'd17,    1'b0, 1'b1); receive(0);
      send(SH_ROR, 16'h8001, 16'd1,     1'b0, 1'b1); receive(5);

      for (int i = 0; i < 8; i++) begin
         send(shift_op_t'($urandom_range(0, 3)), 16'($urandom),
              16'($urandom_range(0, 20)), 1'($urandom), 1'b1);
         receive(i % 3);
      end

      // Flush while passes are in flight.
      send(SH_LSL, 16'h00FF, 16'd16, 1'b0, 1'b0);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_valid",    32'(bus.out_valid), 32'd0);
      check("flush_in_ready", 32'(bus.in_ready),  32'd1);
      repeat (3) @(negedge clk);
      check("flush_no_output", 32'(bus.out_valid), 32'd0);

      // Reset pulse while a result is held.
      send(SH_LSR, 16'hF000, 16'd4, 1'b0, 1'b0);
      guard = 0;
      while (!bus.out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid",    32'(bus.out_valid), 32'd0);
      check("async_rst_in_ready", 32'(bus.in_ready),  32'd1);
      check("async_rst_data",     32'(bus.out_data),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(SH_LSL, 16'h00FF, 16'd8, 1'b0, 1'b1); receive(0);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
